// File: rtl/interp_loop_ctrl.sv
// interp_loop_ctrl: two-level loop sequencer driving an external inner-loop counter register and a row index.
module interp_loop_ctrl #(
  parameter logic [3:0] INNER_LAST = 4'd7,
  parameter logic [3:0] OUTER_LAST = 4'd7
) (
  input  logic       CLK,
  input  logic       RST_ASYNC_N,
  input  logic       START,
  input  logic       ABORT,
  input  logic       STALL,
  input  logic [3:0] CNT_Q,
  output logic       CNT_WE,
  output logic [3:0] CNT_D,
  output logic [3:0] ROW,
  output logic       STEP_EN,
  output logic       ROW_END,
  output logic       BUSY,
  output logic       DONE
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] INIT = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] FIN  = 2'd3;
  logic [1:0] state, state_nxt;
  logic inner_last, row_last, abort_act;
  // Counts past INNER_LAST still close the row so a corrupted counter cannot hang the loop.
  assign inner_last = CNT_Q >= INNER_LAST;
  assign row_last   = ROW >= OUTER_LAST;
  always_comb begin
    abort_act = ABORT && state != IDLE;
    STEP_EN   = state == RUN && !STALL && !ABORT;
    ROW_END   = STEP_EN && inner_last;
    CNT_WE    = abort_act || state == INIT || (STEP_EN && !(inner_last && row_last));
    CNT_D     = (STEP_EN && !inner_last) ? CNT_Q + 4'd1 : 4'd0;
    BUSY      = state != IDLE;
    DONE      = state == FIN && !ABORT;
    state_nxt = abort_act ? IDLE :
                state == IDLE ? (START ? INIT : IDLE) :
                state == INIT ? RUN :
                state == FIN  ? IDLE :
                (ROW_END && row_last) ? FIN : RUN;
  end
  always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
    if (!RST_ASYNC_N) begin
      state <= IDLE;
      ROW   <= 4'd0;
    end else begin
      state <= state_nxt;
      if (state == INIT) ROW <= 4'd0;
      else if (ROW_END && !row_last) ROW <= ROW + 4'd1;
    end
  end
endmodule

// File: tb/tb_interp_loop_ctrl.sv
// tb_interp_loop_ctrl: directed table vectors plus multi-cycle sequences for the loop sequencer.
module tb_interp_loop_ctrl;
  logic clk = 1'b0;
  logic rst_n, start, abort, stall, ovr;
  logic [3:0] ovr_val;
  logic we_a, step_a, rend_a, busy_a, done_a;
  logic [3:0] d_a, row_a, cq_a;
  logic we_s, step_s, rend_s, busy_s, done_s;
  logic [3:0] d_s, row_s, cq_s, cq_s_in;
  logic we_z, step_z, rend_z, busy_z, done_z;
  logic [3:0] d_z, row_z, cq_z;
  int total = 0, passed = 0, fails = 0;
  always #5 clk = ~clk;
  assign cq_s_in = ovr ? ovr_val : cq_s;
  interp_loop_ctrl dut_a (.CLK(clk), .RST_ASYNC_N(rst_n), .START(start), .ABORT(abort), .STALL(stall),
    .CNT_Q(cq_a), .CNT_WE(we_a), .CNT_D(d_a), .ROW(row_a), .STEP_EN(step_a), .ROW_END(rend_a),
    .BUSY(busy_a), .DONE(done_a));
  interp_loop_ctrl #(.INNER_LAST(4'd1), .OUTER_LAST(4'd1)) dut_s (.CLK(clk), .RST_ASYNC_N(rst_n),
    .START(start), .ABORT(abort), .STALL(stall), .CNT_Q(cq_s_in), .CNT_WE(we_s), .CNT_D(d_s),
    .ROW(row_s), .STEP_EN(step_s), .ROW_END(rend_s), .BUSY(busy_s), .DONE(done_s));
  interp_loop_ctrl #(.INNER_LAST(4'd0), .OUTER_LAST(4'd0)) dut_z (.CLK(clk), .RST_ASYNC_N(rst_n),
    .START(start), .ABORT(abort), .STALL(stall), .CNT_Q(cq_z), .CNT_WE(we_z), .CNT_D(d_z),
    .ROW(row_z), .STEP_EN(step_z), .ROW_END(rend_z), .BUSY(busy_z), .DONE(done_z));
  // External counter registers, one-cycle write latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cq_a <= 4'd0;
      cq_s <= 4'd0;
      cq_z <= 4'd0;
    end else begin
      if (we_a) cq_a <= d_a;
      if (we_s) cq_s <= d_s;
      if (we_z) cq_z <= d_z;
    end
  end
  typedef struct {
    logic start, abort, stall, we;
    logic [3:0] d, row;
    logic step, rend, busy, done;
    logic [3:0] cq;
  } vec_t;
  vec_t tbl[22];
  function automatic vec_t v(input int s, a, st, we, d, row, step, re, b, dn, cq);
    vec_t r;
    r.start = 1'(s); r.abort = 1'(a); r.stall = 1'(st); r.we = 1'(we); r.d = 4'(d); r.row = 4'(row);
    r.step = 1'(step); r.rend = 1'(re); r.busy = 1'(b); r.done = 1'(dn); r.cq = 4'(cq);
    return r;
  endfunction
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic settle();
    start = 0; stall = 0; ovr = 0; abort = 1;
    cyc();
    abort = 0;
    cyc();
  endtask
  initial begin
    int steps, first_step, last_step, rends, rend_bad, done_cnt, done_cyc, busy_cnt, busy_first;
    int nst, sbad, post, post_ok, aborted, ab_ok, ab_c, after_busy, after_cq, restart_ok, idle_bad;
    logic [16:0] act, exp;
    rst_n = 0; start = 0; abort = 0; stall = 0; ovr = 0; ovr_val = 0;
    // IL=1, OL=1 instance: cols start,abort,stall | we,d,row,step,rend,busy,done,cq
    tbl[0]  = v(1,0,0, 0,0,0,0,0,0,0,0);
    tbl[1]  = v(0,0,0, 1,0,0,0,0,1,0,0);
    tbl[2]  = v(0,0,0, 1,1,0,1,0,1,0,0);
    tbl[3]  = v(0,0,1, 0,0,0,0,0,1,0,1);
    tbl[4]  = v(0,0,0, 1,0,0,1,1,1,0,1);
    tbl[5]  = v(0,0,0, 1,1,1,1,0,1,0,0);
    tbl[6]  = v(0,0,0, 0,0,1,1,1,1,0,1);
    tbl[7]  = v(0,0,0, 0,0,1,0,0,1,1,1);
    tbl[8]  = v(1,1,0, 0,0,1,0,0,0,0,1);
    tbl[9]  = v(0,0,0, 1,0,1,0,0,1,0,1);
    tbl[10] = v(0,0,0, 1,1,0,1,0,1,0,0);
    tbl[11] = v(0,1,1, 1,0,0,0,0,1,0,1);
    tbl[12] = v(1,0,0, 0,0,0,0,0,0,0,0);
    tbl[13] = v(1,0,0, 1,0,0,0,0,1,0,0);
    tbl[14] = v(1,0,0, 1,1,0,1,0,1,0,0);
    tbl[15] = v(1,0,0, 1,0,0,1,1,1,0,1);
    tbl[16] = v(1,0,0, 1,1,1,1,0,1,0,0);
    tbl[17] = v(1,0,0, 0,0,1,1,1,1,0,1);
    tbl[18] = v(1,0,0, 0,0,1,0,0,1,1,1);
    tbl[19] = v(1,0,0, 0,0,1,0,0,0,0,1);
    tbl[20] = v(1,0,0, 1,0,1,0,0,1,0,1);
    tbl[21] = v(0,0,0, 1,1,0,1,0,1,0,0);
    #12;
    chk("reset_outputs", int'({we_a, d_a, row_a, step_a, rend_a, busy_a, done_a}), 0);
    rst_n = 1;
    cyc();
    for (int i = 0; i < 22; i++) begin
      start = tbl[i].start; abort = tbl[i].abort; stall = tbl[i].stall;
      @(negedge clk);
      act = {we_s, we_s ? d_s : 4'd0, row_s, step_s, rend_s, busy_s, done_s, cq_s};
      exp = {tbl[i].we, tbl[i].we ? tbl[i].d : 4'd0, tbl[i].row, tbl[i].step, tbl[i].rend,
             tbl[i].busy, tbl[i].done, tbl[i].cq};
      chk($sformatf("vec%0d", i), int'(act), int'(exp));
      cyc();
    end
    settle();
    // Counter above INNER_LAST terminates each row.
    start = 1; cyc(); start = 0; cyc();
    ovr = 1; ovr_val = 4'd5;
    @(negedge clk);
    chk("ovr_row0", int'({step_s, rend_s, we_s, d_s}), 'b1_1_1_0000);
    cyc();
    @(negedge clk);
    chk("ovr_row1", int'({step_s, rend_s, we_s, row_s}), 'b1_1_0_0001);
    cyc();
    ovr = 0;
    @(negedge clk);
    chk("ovr_done", int'({done_s, busy_s}), 'b11);
    cyc();
    settle();
    // Full default sequence.
    steps = 0; first_step = -1; last_step = -1; rends = 0; rend_bad = 0;
    done_cnt = 0; done_cyc = -1; busy_cnt = 0; busy_first = -1;
    for (int c = 0; c < 70; c++) begin
      start = (c == 0);
      @(negedge clk);
      if (step_a) begin
        steps++;
        if (first_step < 0) first_step = c;
        last_step = c;
      end
      if (rend_a) begin
        rends++;
        if (c < 9 || (c - 9) % 8 != 0) rend_bad++;
      end
      if (done_a) begin done_cnt++; done_cyc = c; end
      if (busy_a) begin busy_cnt++; if (busy_first < 0) busy_first = c; end
      cyc();
    end
    chk("steps", steps, 64);
    chk("first_step", first_step, 2);
    chk("last_step", last_step, 65);
    chk("row_end_count", rends, 8);
    chk("row_end_pos", rend_bad, 0);
    chk("done_count", done_cnt, 1);
    chk("done_cycle", done_cyc, 66);
    chk("busy_count", busy_cnt, 66);
    chk("busy_first", busy_first, 1);
    settle();
    // Stall for 3 cycles at ROW=2, CNT_Q=4.
    nst = 0; sbad = 0; post = 0; post_ok = 0; done_cyc = -1;
    for (int c = 0; c < 80; c++) begin
      start = (c == 0);
      stall = busy_a && row_a == 4'd2 && cq_a == 4'd4 && nst < 3;
      @(negedge clk);
      if (stall) begin
        nst++;
        if (we_a || row_a != 4'd2) sbad++;
      end else if (nst == 3 && post == 0) begin
        post = 1;
        post_ok = int'(step_a && we_a && d_a == 4'd5);
      end
      if (done_a) done_cyc = c;
      cyc();
    end
    stall = 0;
    chk("stall_cycles", nst, 3);
    chk("stall_hold", sbad, 0);
    chk("stall_resume", post_ok, 1);
    chk("stall_done_cycle", done_cyc, 69);
    settle();
    // Abort at ROW=3, CNT_Q=6.
    aborted = 0; ab_ok = 0; ab_c = -10; after_busy = -1; after_cq = -1; done_cnt = 0;
    for (int c = 0; c < 80; c++) begin
      start = (c == 0);
      abort = busy_a && row_a == 4'd3 && cq_a == 4'd6 && aborted == 0;
      @(negedge clk);
      if (abort) begin
        aborted = 1; ab_c = c;
        ab_ok = int'(we_a && d_a == 4'd0 && !step_a && !done_a);
      end
      if (c == ab_c + 1) begin after_busy = int'(busy_a); after_cq = int'(cq_a); end
      if (done_a) done_cnt++;
      cyc();
    end
    abort = 0;
    chk("abort_seen", aborted, 1);
    chk("abort_outputs", ab_ok, 1);
    chk("abort_busy", after_busy, 0);
    chk("abort_cnt", after_cq, 0);
    chk("abort_no_done", done_cnt, 0);
    restart_ok = 0;
    for (int c = 0; c < 3; c++) begin
      start = (c == 0);
      @(negedge clk);
      if (c == 2) restart_ok = int'(step_a && row_a == 4'd0 && cq_a == 4'd0);
      cyc();
    end
    chk("abort_restart", restart_ok, 1);
    settle();
    // Single-iteration instance.
    steps = 0; rends = 0; done_cyc = -1;
    for (int c = 0; c < 8; c++) begin
      start = (c == 0);
      @(negedge clk);
      if (step_z) begin steps++; if (rend_z) rends++; end
      if (done_z) done_cyc = c;
      cyc();
    end
    chk("z_steps", steps, 1);
    chk("z_row_end", rends, 1);
    chk("z_done_cycle", done_cyc, 3);
    settle();
    // Asynchronous reset mid-RUN.
    start = 1; cyc(); start = 0;
    for (int c = 0; c < 20; c++) cyc();
    #3 rst_n = 0;
    #1;
    chk("async_reset", int'({we_a, d_a, row_a, step_a, rend_a, busy_a, done_a}), 0);
    cyc(); cyc();
    @(negedge clk);
    rst_n = 1;
    cyc();
    idle_bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (busy_a || step_a || we_a || done_a) idle_bad++;
      cyc();
    end
    chk("post_reset_idle", idle_bad, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/interp_loop_ctrl.md
INTERP_LOOP_CTRL -- requirements
Module: interp_loop_ctrl

Interface
REQ-001 SHALL have parameter INNER_LAST, default 4'd7: last inner-loop index (inner iterations = INNER_LAST+1).
REQ-002 SHALL have parameter OUTER_LAST, default 4'd7: last outer-loop (row) index (rows = OUTER_LAST+1).
REQ-003 CLK  input  1  clock; all state updates on rising edge.
REQ-004 RST_ASYNC_N  input  1  reset, asynchronous, active-low.
REQ-005 START  input  1  request one full loop sequence; sampled only in IDLE.
REQ-006 ABORT  input  1  terminate the sequence in progress.
REQ-007 STALL  input  1  datapath not ready; freezes iteration.
REQ-008 CNT_Q  input  4  current value of the external 4-bit loop-counter register.
REQ-009 CNT_WE  output  1  write enable to the counter register.
REQ-010 CNT_D  output  4  write data to the counter register.
REQ-011 ROW  output  4  current outer-loop index, registered.
REQ-012 STEP_EN  output  1  datapath performs iteration (ROW, CNT_Q) this cycle.
REQ-013 ROW_END  output  1  current step is the last inner iteration of ROW.
REQ-014 BUSY  output  1  high in every state except IDLE.
REQ-015 DONE  output  1  one-cycle pulse after the final step.

Function
REQ-016 SHALL implement FSM states IDLE, INIT, RUN, FIN.
REQ-017 IDLE: START=1 -> INIT; otherwise stay; CNT_WE=0, STEP_EN=0.
REQ-018 INIT (one cycle): CNT_WE=1, CNT_D=0, ROW<=0; -> RUN.
REQ-019 RUN: STEP_EN = !STALL && !ABORT, combinational.
REQ-020 RUN, step with CNT_Q<INNER_LAST: CNT_WE=1, CNT_D=CNT_Q+1 (4-bit), ROW_END=0.
REQ-021 RUN, step with CNT_Q==INNER_LAST and ROW<OUTER_LAST: ROW_END=1, CNT_WE=1, CNT_D=0, ROW<=ROW+1; stay in RUN.
REQ-022 RUN, step with CNT_Q==INNER_LAST and ROW==OUTER_LAST: ROW_END=1, CNT_WE=0; -> FIN.
REQ-023 RUN with STALL=1: STEP_EN=0, ROW_END=0, CNT_WE=0, ROW held; stall has no length limit.
REQ-024 FIN (one cycle): DONE=1, BUSY=1; -> IDLE.
REQ-025 ABORT=1 in INIT, RUN or FIN: next state IDLE; CNT_WE=1, CNT_D=0; STEP_EN=0; no DONE pulse; ABORT has priority over STALL and START.
REQ-026 ABORT in IDLE SHALL be ignored; START outside IDLE SHALL be ignored.
REQ-027 START held high across FIN->IDLE SHALL begin a new sequence on the cycle IDLE samples it.
REQ-028 CNT_Q values above INNER_LAST in RUN SHALL be treated as CNT_Q==INNER_LAST (row termination), so the FSM always terminates.
REQ-029 Latency: START at cycle 0 -> INIT at cycle 1 -> first STEP_EN at cycle 2 with CNT_Q=0; without stalls, total steps = (INNER_LAST+1)*(OUTER_LAST+1), and DONE occurs the cycle after the final step.
REQ-030 The counter register SHALL be written only through CNT_WE/CNT_D, with one-cycle write latency.

Reset
REQ-031 While RST_ASYNC_N=0: state=IDLE, ROW=0, CNT_WE=0, CNT_D=0, STEP_EN=0, ROW_END=0, BUSY=0, DONE=0, immediately and independent of CLK.
REQ-032 Reset asserted mid-sequence SHALL abandon it with no DONE; after release the block waits in IDLE for START.

Verification
REQ-033 Defaults, START pulse at cycle 0, no stall -> STEP_EN high in cycles 2..65 (64 steps), ROW_END high at cycles 9,17,...,65, DONE at cycle 66, BUSY cycles 1..66.
REQ-034 STALL=1 for 3 cycles while CNT_Q=4, ROW=2 -> CNT_WE=0 and ROW=2 held for 3 cycles, then CNT_D=5; total sequence 3 cycles longer.
REQ-035 ABORT at ROW=3, CNT_Q=6 -> next cycle IDLE, CNT_WE=1 with CNT_D=0, BUSY=0, no DONE; a later START restarts at ROW=0, CNT_Q=0.
REQ-036 INNER_LAST=0, OUTER_LAST=0 -> exactly one step with ROW_END=1, then DONE the next cycle.
REQ-037 START held high continuously -> back-to-back sequences, each with one DONE pulse followed by IDLE, INIT, RUN.
REQ-038 RST_ASYNC_N low mid-RUN between clock edges -> all outputs 0 immediately, ROW=0; no activity until a new START.
